pwm_angle_decoder: RTL and testbench



---
 rtl/pwm_angle_decoder.sv | 167 ++++++++++++++++
 tb/tb_pwm_angle_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_angle_decoder.sv
// Servo PWM pulse-width decoder: measures each high time and converts it to a 0-180 degree angle.
// Tracks lock (two consecutive good pulses), width errors and loss of signal.
module pwm_angle_decoder #(
  parameter int DUR_CLOCK_NUM = 1000000,
  parameter int DEGREE_MIN    = 25000,
  parameter int DEGREE_MAX    = 125000,
  parameter int WIDTH_TOL     = 5000,
  parameter int TIMEOUT       = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_valid,
  output logic       locked,
  output logic       err_width,
  output logic       timeout
);

  localparam int STEP = (DEGREE_MAX - DEGREE_MIN) / 180;
  localparam int HALF = STEP / 2;

  localparam logic [21:0] MIN_C      = 22'(DEGREE_MIN);
  localparam logic [21:0] MAX_C      = 22'(DEGREE_MAX);
  localparam logic [21:0] STEP_C     = 22'(STEP);
  localparam logic [21:0] HALF_C     = 22'(HALF);
  localparam logic [21:0] LO_LIM_C   = 22'(DEGREE_MIN - WIDTH_TOL);
  localparam logic [21:0] HI_LIM_C   = 22'(DEGREE_MAX + WIDTH_TOL);
  localparam logic [21:0] TMO_C      = 22'(TIMEOUT);
  localparam logic [21:0] TMO_LAST_C = 22'(TIMEOUT - 1);

  // Loss of signal must not be declared within one legal frame.
  if (TIMEOUT <= DUR_CLOCK_NUM) begin : g_bad_timeout
    $error("TIMEOUT must exceed DUR_CLOCK_NUM");
  end

  typedef enum logic [2:0] {
    S_WAIT_LOW,
    S_WAIT_RISE,
    S_HIGH,
    S_CHECK,
    S_DIV
  } state_t;

  state_t      state_q;
  logic        sync1_q, sync2_q, prev_q;
  logic [21:0] width_q, per_q, num_q;
  logic [8:0]  q_q;
  logic [1:0]  good_cnt_q;
  logic [7:0]  angle_q;
  logic        valid_q, locked_q, err_q, tmo_q;
  logic        rise, fall;
  logic [21:0] width_d;

  assign rise    = sync2_q & ~prev_q;
  assign fall    = ~sync2_q & prev_q;
  assign width_d = sat_inc(width_q);

  function automatic logic [21:0] sat_inc(input logic [21:0] v);
    return (v == '1) ? v : v + 22'd1;
  endfunction

  // Clamp to the legal range, then bias by half a step so the divide rounds half-up.
  function automatic logic [21:0] clamp_num(input logic [21:0] w);
    logic [21:0] c;
    if (w < MIN_C)      c = MIN_C;
    else if (w > MAX_C) c = MAX_C;
    else                c = w;
    return c - MIN_C + HALF_C;
  endfunction

  function automatic logic [7:0] angle_sat(input logic [8:0] v);
    return (v > 9'd180) ? 8'd180 : v[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT_LOW;
      // Synchronizer preset high so a pulse in progress at reset never looks like a rise.
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      width_q    <= '0;
      per_q      <= '0;
      num_q      <= '0;
      q_q        <= '0;
      good_cnt_q <= '0;
      angle_q    <= 8'd90;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;

      if (rise)                per_q <= '0;
      else if (per_q != TMO_C) per_q <= per_q + 22'd1;

      if (!rise && per_q == TMO_LAST_C) begin
        tmo_q      <= 1'b1;
        locked_q   <= 1'b0;
        good_cnt_q <= '0;
        state_q    <= S_WAIT_LOW;
      end else begin
        case (state_q)
          S_WAIT_LOW: begin
            if (!sync2_q) state_q <= S_WAIT_RISE;
          end
          S_WAIT_RISE: begin
            if (rise) begin
              width_q <= '0;
              state_q <= S_HIGH;
            end
          end
          S_HIGH: begin
            width_q <= width_d;
            if (fall) begin
              state_q <= S_CHECK;
            end else if (width_d > HI_LIM_C) begin
              err_q      <= 1'b1;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
              state_q    <= S_WAIT_LOW;
            end
          end
          S_CHECK: begin
            if (width_q < LO_LIM_C) begin
              err_q      <= 1'b1;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
              state_q    <= S_WAIT_RISE;
            end else begin
              num_q   <= clamp_num(width_q);
              q_q     <= '0;
              state_q <= S_DIV;
            end
          end
          S_DIV: begin
            if (num_q >= STEP_C) begin
              num_q <= num_q - STEP_C;
              q_q   <= q_q + 9'd1;
            end else begin
              angle_q <= angle_sat(q_q);
              valid_q <= 1'b1;
              if (good_cnt_q != 2'd2) good_cnt_q <= good_cnt_q + 2'd1;
              if (good_cnt_q != 2'd0) locked_q <= 1'b1;
              state_q <= S_WAIT_RISE;
            end
          end
          default: state_q <= S_WAIT_LOW;
        endcase
      end
    end
  end

  assign angle       = angle_q;
  assign angle_valid = valid_q;
  assign locked      = locked_q;
  assign err_width   = err_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_pwm_angle_decoder.sv
// Directed bench for pwm_angle_decoder with a scaled-down timing map:
// 0 deg = 900 clocks, 180 deg = 2700 clocks, step 10, tolerance 200, timeout 8000.
module tb_pwm_angle_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] angle;
  logic       angle_valid, locked, err_width, timeout;

  pwm_angle_decoder #(
    .DUR_CLOCK_NUM(4000),
    .DEGREE_MIN   (900),
    .DEGREE_MAX   (2700),
    .WIDTH_TOL    (200),
    .TIMEOUT      (8000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .angle      (angle),
    .angle_valid(angle_valid),
    .locked     (locked),
    .err_width  (err_width),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_err = 0, n_to = 0, n_multi = 0;
  int last_valid_cyc = 0, last_err_cyc = 0, fall_cyc = 0;
  int n_checks = 0, n_fail = 0;

  always @(negedge clk) begin
    if (angle_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (err_width) begin
      n_err++;
      last_err_cyc = cyc;
    end
    if (timeout) n_to++;
    if (int'(angle_valid) + int'(err_width) + int'(timeout) > 1) n_multi++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame(input int hi, input int lo);
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1 pwm_in = 1'b0;
    fall_cyc = cyc;
    repeat (lo) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int width;
    bit exp_err;
    int exp_angle;
    bit exp_locked;
  } vec_t;

  vec_t vecs[16];
  int v0, e0, t0;

  initial begin
    vecs[0]  = '{1800, 1'b0, 90,  1'b0};
    vecs[1]  = '{1800, 1'b0, 90,  1'b1};
    vecs[2]  = '{900,  1'b0, 0,   1'b1};
    vecs[3]  = '{2699, 1'b0, 180, 1'b1};
    vecs[4]  = '{2700, 1'b0, 180, 1'b1};
    vecs[5]  = '{925,  1'b0, 3,   1'b1};
    vecs[6]  = '{924,  1'b0, 2,   1'b1};
    vecs[7]  = '{1234, 1'b0, 33,  1'b1};
    vecs[8]  = '{850,  1'b0, 0,   1'b1};
    vecs[9]  = '{2750, 1'b0, 180, 1'b1};
    vecs[10] = '{700,  1'b0, 0,   1'b1};
    vecs[11] = '{699,  1'b1, 0,   1'b0};
    vecs[12] = '{1800, 1'b0, 90,  1'b0};
    vecs[13] = '{3100, 1'b1, 90,  1'b0};
    vecs[14] = '{2900, 1'b0, 180, 1'b0};
    vecs[15] = '{1500, 1'b0, 60,  1'b1};

    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_angle", int'(angle), 90);
    check("reset_valid", int'(angle_valid), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_err", int'(err_width), 0);
    check("reset_timeout", int'(timeout), 0);

    for (int i = 0; i < 16; i++) begin
      v0 = n_valid;
      e0 = n_err;
      frame(vecs[i].width, 600);
      if (vecs[i].exp_err) begin
        check($sformatf("w%0d_valid_cnt", vecs[i].width), n_valid - v0, 0);
        check($sformatf("w%0d_err_cnt", vecs[i].width), n_err - e0, 1);
        if (vecs[i].width > 2901)
          check($sformatf("w%0d_err_before_fall", vecs[i].width),
                int'(last_err_cyc < fall_cyc), 1);
      end else begin
        check($sformatf("w%0d_valid_cnt", vecs[i].width), n_valid - v0, 1);
        check($sformatf("w%0d_err_cnt", vecs[i].width), n_err - e0, 0);
        check($sformatf("w%0d_latency", vecs[i].width),
              last_valid_cyc - fall_cyc, vecs[i].exp_angle + 5);
      end
      check($sformatf("w%0d_angle", vecs[i].width), int'(angle), vecs[i].exp_angle);
      check($sformatf("w%0d_locked", vecs[i].width), int'(locked), int'(vecs[i].exp_locked));
    end
    check("no_timeout_in_frames", n_to, 0);

    // Input held low after lock
    t0 = n_to;
    repeat (8000) @(negedge clk);
    check("low_timeout_cnt", n_to - t0, 1);
    check("low_timeout_locked", int'(locked), 0);
    check("low_timeout_angle", int'(angle), 60);
    repeat (1000) @(negedge clk);
    check("low_timeout_single", n_to - t0, 1);

    frame(1800, 600);
    check("relock1_locked", int'(locked), 0);
    frame(1800, 600);
    check("relock2_locked", int'(locked), 1);
    check("relock2_angle", int'(angle), 90);

    // Input held high
    v0 = n_valid; e0 = n_err; t0 = n_to;
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (8300) @(negedge clk);
    check("high_err_cnt", n_err - e0, 1);
    check("high_timeout_cnt", n_to - t0, 1);
    check("high_valid_cnt", n_valid - v0, 0);
    check("high_locked", int'(locked), 0);
    check("high_angle", int'(angle), 90);
    #1 pwm_in = 1'b0;
    repeat (600) @(negedge clk);

    // Reset released mid-pulse
    @(posedge clk); #1 pwm_in = 1'b1; reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midpulse_reset_angle", int'(angle), 90);
    check("midpulse_reset_locked", int'(locked), 0);
    v0 = n_valid;
    repeat (1000) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (600) @(negedge clk);
    check("midpulse_no_strobe", n_valid - v0, 0);
    frame(1234, 600);
    check("midpulse_next_cnt", n_valid - v0, 1);
    check("midpulse_next_angle", int'(angle), 33);

    // Reset during the divide
    @(posedge clk); #1 pwm_in = 1'b1;
    repeat (2700) @(posedge clk);
    #1 pwm_in = 1'b0;
    v0 = n_valid;
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("div_reset_angle", int'(angle), 90);
    check("div_reset_valid", int'(angle_valid), 0);
    repeat (300) @(negedge clk);
    check("div_reset_no_strobe", n_valid - v0, 0);
    frame(1500, 600);
    check("div_resume1_angle", int'(angle), 60);
    check("div_resume1_locked", int'(locked), 0);
    frame(1500, 600);
    check("div_resume2_locked", int'(locked), 1);
    check("div_resume_cnt", n_valid - v0, 2);

    check("strobes_exclusive", n_multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
